// File: rtl/serial_frame_sync_pkg.sv
// Shared types and defaults for the serial frame synchroniser.
package serial_frame_sync_pkg;

    // Receiver state: hunting for the sync pattern, or capturing payload bits.
    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_e;

    // Default sync pattern; the first-received bit is the MSB.
    localparam logic [3:0] DEF_SYNC_PATTERN = 4'b1011;

endpackage

// File: rtl/serial_frame_sync_window.sv
// Sync hunter: sliding window of accepted bits, a saturating fill counter
// and a comparator.
// match is combinational. It looks at the window plus the bit now on Din,
// so the FSM can leave HUNT on the very edge that accepts the last sync bit.
module sync_window #(
    parameter int              SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011
) (
    input  logic clk,
    input  logic Reset,
    input  logic En,
    input  logic clr,
    input  logic Din,
    output logic match
);
    localparam int FW = $clog2(SYNC_W + 1);

    logic [SYNC_W-2:0] win;
    logic [FW-1:0]     fill;
    logic [SYNC_W-1:0] cand;

    assign cand = {win, Din};

    // fill blocks matches on reset-zero history (important when the pattern has leading zeros).
    assign match = (fill >= FW'(SYNC_W - 1)) && (cand == SYNC_PATTERN);

    // Shift accepted bits into the window; clr wipes the history so that a
    // fresh hunt needs a complete pattern.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            win  <= '0;
            fill <= '0;
        end else if (clr) begin
            win  <= '0;
            fill <= '0;
        end else if (En) begin
            win <= cand[SYNC_W-2:0];
            if (fill != FW'(SYNC_W))
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_sync.sv
// Serial frame synchroniser.
// It hunts for a sync pattern, deserialises the next DATA_W bits MSB-first,
// pulses Valid with each new word and keeps a saturating frame count.
module serial_frame_sync
    import serial_frame_sync_pkg::*;
#(
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
    parameter int                DATA_W       = 8,
    parameter int                CNT_W        = 8
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Din,
    input  logic              En,
    output logic [DATA_W-1:0] Data,
    output logic              Valid,
    output logic              Locked,
    output logic [CNT_W-1:0]  FrameCnt
);
    localparam int BW = $clog2(DATA_W + 1);

    generate
        if (SYNC_W < 2 || DATA_W < 1) begin : g_bad_param
            $error("serial_frame_sync: SYNC_W must be >= 2 and DATA_W >= 1");
        end
    endgenerate

    state_e            state, state_nx;
    logic              match, hit, last, clr;
    logic [DATA_W-1:0] payload, pl_next;
    logic [DATA_W:0]   pl_ext;
    logic [BW-1:0]     bitcnt;

    // Window is held clear for the whole capture, so the payload can never seed a relock.
    assign hit    = En && (state == ST_HUNT) && match;
    assign last   = En && (state == ST_CAPTURE) && (bitcnt == BW'(DATA_W - 1));
    assign clr    = (state == ST_CAPTURE) || hit;
    assign Locked = (state == ST_CAPTURE);

    // Widen by one bit so the shift also works for DATA_W=1.
    assign pl_ext  = {payload, Din};
    assign pl_next = pl_ext[DATA_W-1:0];

    sync_window #(
        .SYNC_W       (SYNC_W),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_win (
        .clk   (clk),
        .Reset (Reset),
        .En    (En),
        .clr   (clr),
        .Din   (Din),
        .match (match)
    );

    // State register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state <= ST_HUNT;
        else        state <= state_nx;
    end

    // Next-state logic: a match enters CAPTURE and the last payload bit returns to HUNT.
    always_comb begin
        state_nx = state;
        case (state)
            ST_HUNT:    if (hit)  state_nx = ST_CAPTURE;
            ST_CAPTURE: if (last) state_nx = ST_HUNT;
            default:    state_nx = ST_HUNT;
        endcase
    end

    // Payload shift, bit count, output word, Valid pulse and saturating frame count.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            payload  <= '0;
            bitcnt   <= '0;
            Data     <= '0;
            Valid    <= 1'b0;
            FrameCnt <= '0;
        end else begin
            Valid <= 1'b0;
            if (hit) begin
                payload <= '0;
                bitcnt  <= '0;
            end else if (En && state == ST_CAPTURE) begin
                payload <= pl_next;
                bitcnt  <= bitcnt + 1'b1;
                if (last) begin
                    Data   <= pl_next;
                    Valid  <= 1'b1;
                    bitcnt <= '0;
                    if (FrameCnt != '1)
                        FrameCnt <= FrameCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_sync.sv
// Self-checking bench for serial_frame_sync.
// It runs directed frames plus a long random run against a list-based
// reference model.
module tb_serial_frame_sync;
    localparam int SYNC_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int PAT    = 4'b1011;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Din = 1'b0;
    logic              En = 1'b0;
    logic [DATA_W-1:0] Data;
    logic              Valid;
    logic              Locked;
    logic [CNT_W-1:0]  FrameCnt;

    int checks = 0;
    int errors = 0;

    // Reference model: recent hunt bits as a list, payload as an integer.
    int hist[$];
    bit m_locked;
    bit m_valid;
    int m_word, m_n, m_data, m_cnt;
    int vcount;

    serial_frame_sync #(
        .SYNC_W       (SYNC_W),
        .SYNC_PATTERN (4'b1011),
        .DATA_W       (DATA_W),
        .CNT_W        (CNT_W)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .Din      (Din),
        .En       (En),
        .Data     (Data),
        .Valid    (Valid),
        .Locked   (Locked),
        .FrameCnt (FrameCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_locked = 0;
        m_valid  = 0;
        m_word   = 0;
        m_n      = 0;
        m_data   = 0;
        m_cnt    = 0;
    endtask

    task automatic model_step(input bit d, input bit e);
        int v;
        m_valid = 0;
        if (!e) return;
        if (!m_locked) begin
            hist.push_back(d);
            if (hist.size() > SYNC_W) void'(hist.pop_front());
            if (hist.size() == SYNC_W) begin
                v = 0;
                foreach (hist[i]) v = v * 2 + hist[i];
                if (v == PAT) begin
                    m_locked = 1;
                    m_word   = 0;
                    m_n      = 0;
                    hist.delete();
                end
            end
        end else begin
            m_word = m_word * 2 + d;
            m_n++;
            if (m_n == DATA_W) begin
                m_data   = m_word;
                m_valid  = 1;
                m_cnt    = (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
                m_locked = 0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, check all outputs just after it.
    task automatic cycle(input bit d, input bit e);
        Din = d;
        En  = e;
        @(posedge clk);
        model_step(d, e);
        #1;
        chk("data",   Data,     m_data);
        chk("valid",  Valid,    m_valid);
        chk("locked", Locked,   m_locked);
        chk("cnt",    FrameCnt, m_cnt);
        if (Valid) vcount++;
    endtask

    task automatic send(input int val, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(((val >> i) & 1) != 0, 1'b1);
            if (gaps) cycle(1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        #2 Reset = 1'b0;
        model_reset();
        #1;
        chk("rst_data",   Data,     0);
        chk("rst_locked", Locked,   0);
        chk("rst_valid",  Valid,    0);
        chk("rst_cnt",    FrameCnt, 0);
        #1 Reset = 1'b1;
    endtask

    initial begin
        int cnt_exp[5];
        cnt_exp = '{1, 2, 3, 3, 3};
        model_reset();

        // 1: reset held low for 20 ns while Din toggles.
        En = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Din = i[0];
            #5;
            chk("t1_data",   Data,     0);
            chk("t1_valid",  Valid,    0);
            chk("t1_locked", Locked,   0);
            chk("t1_cnt",    FrameCnt, 0);
        end
        @(negedge clk);
        Reset = 1'b1;

        // 2: basic frame.
        vcount = 0;
        send(4'b1011, 4, 0);
        send(8'hA5, 8, 0);
        chk("t2_vcount", vcount, 1);
        chk("t2_data",   Data,   8'hA5);
        chk("t2_cnt",    FrameCnt, 1);

        // 3: overlap hunt and payload immunity.
        do_reset();
        vcount = 0;
        send(6'b101011, 6, 0);
        send(8'hBB, 8, 0);
        send(0, 4, 0);
        chk("t3_vcount", vcount, 1);
        chk("t3_data",   Data,   8'hBB);
        chk("t3_locked", Locked, 0);
        chk("t3_cnt",    FrameCnt, 1);

        // 4: En gaps on alternate cycles.
        do_reset();
        vcount = 0;
        send(4'b1011, 4, 1);
        send(8'hA5, 8, 1);
        chk("t4_vcount", vcount, 1);
        chk("t4_data",   Data,   8'hA5);

        // 5: reset in the middle of a payload.
        send(4'b1011, 4, 0);
        send(4'b1100, 4, 0);
        chk("t5_locked_pre", Locked, 1);
        do_reset();
        send(4'b1011, 4, 0);
        send(8'hFF, 8, 0);
        chk("t5_data", Data,     8'hFF);
        chk("t5_cnt",  FrameCnt, 1);

        // 6: back-to-back frames saturate the 2-bit counter.
        do_reset();
        vcount = 0;
        for (int f = 0; f < 5; f++) begin
            send(4'b1011, 4, 0);
            send(8'h0F, 8, 0);
            chk("t6_cnt",  FrameCnt, cnt_exp[f]);
            chk("t6_data", Data,     8'h0F);
        end
        chk("t6_vcount", vcount, 5);

        // Random bits with random En and occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
